givens_row_sequencer: RTL and testbench

- Controller that drives the shared cordic core to apply one Givens rotation to a pair of matrix rows, for the QR-decomposition inverse path.
- Column 0 runs a vectoring pass that zeroes the lower element and captures the rotation angle theta.
- Columns 1..N_COLS-1 each run a rotation pass by -theta.
- Sits between the QR scheduler (valid/ready column-pair streams) and the cordic master ports. All data is Q8.24 signed.

---
 rtl/givens_row_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_givens_row_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/givens_row_sequencer.sv
// Sequences one Givens rotation over a row pair through a shared cordic core:
// column 0 vectors to capture theta, later columns rotate by -theta.
// Optional watchdog on the cordic handshake: define GIVENS_TIMEOUT_EN.
module givens_row_sequencer #(
  parameter int DATA_W      = 32,
  parameter int N_COLS      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic [3:0]               out_col,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] theta,
  output logic                     theta_valid,
  output logic                     busy,
  output logic                     cor_select,
  output logic                     cor_enable,
  output logic signed [DATA_W-1:0] cor_x_in,
  output logic signed [DATA_W-1:0] cor_y_in,
  output logic signed [DATA_W-1:0] cor_z_in,
  input  logic signed [DATA_W-1:0] cor_x_out,
  input  logic signed [DATA_W-1:0] cor_y_out,
  input  logic signed [DATA_W-1:0] cor_z_out,
  input  logic                     cor_done
`ifdef GIVENS_TIMEOUT_EN
  ,
  output logic                     err
`endif
);

  if (N_COLS < 2 || N_COLS > 16 || DATA_W < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("givens_row_sequencer: illegal parameter set");
  end

  localparam logic [3:0] LAST_COL = 4'(N_COLS - 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_RUN    = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]               r_col;
  logic signed [DATA_W-1:0] r_theta;
  logic                     r_theta_valid;
  logic                     r_cor_select;
  logic signed [DATA_W-1:0] r_cor_x_in;
  logic signed [DATA_W-1:0] r_cor_y_in;
  logic signed [DATA_W-1:0] r_cor_z_in;
  logic signed [DATA_W-1:0] r_out_x;
  logic signed [DATA_W-1:0] r_out_y;

  logic w_accept;
  logic w_done;
  logic w_out_hs;
  logic w_col0;
  logic w_timeout;

  // Two's-complement negate; the most negative code has no positive twin.
  function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] a);
    logic signed [DATA_W-1:0] min_v;
    min_v = {1'b1, {(DATA_W-1){1'b0}}};
    if (a == min_v) begin
      return ~min_v;
    end
    return -a;
  endfunction

  assign w_col0   = (r_col == 4'd0);
  assign w_accept = (r_state == S_ACCEPT) && in_valid;
  assign w_done   = (r_state == S_RUN) && cor_done;
  assign w_out_hs = (r_state == S_OUT) && out_ready;

`ifdef GIVENS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // Counter starts at zero on RUN entry, so the last RUN cycle is TIMEOUT_CYC-1.
  assign w_timeout = (r_state == S_RUN) && !cor_done && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACCEPT: begin
        if (in_valid) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cor_done) begin
          w_next = S_OUT;
        end else if (w_timeout) begin
          w_next = S_ACCEPT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_next = S_ACCEPT;
        end
      end
      default: w_next = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= 4'd0;
    end else if (w_out_hs) begin
      r_col <= (r_col == LAST_COL) ? 4'd0 : r_col + 4'd1;
    end else if (w_timeout) begin
      r_col <= 4'd0;
    end
  end

  // Operands latch on acceptance and stay put for the whole cordic run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cor_x_in   <= '0;
      r_cor_y_in   <= '0;
      r_cor_z_in   <= '0;
      r_cor_select <= 1'b0;
    end else if (w_accept) begin
      r_cor_x_in   <= in_x;
      r_cor_y_in   <= in_y;
      r_cor_select <= w_col0;
      r_cor_z_in   <= w_col0 ? '0 : sat_neg(r_theta);
    end
  end

  // Results are captured once, on the first cor_done seen in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_x       <= '0;
      r_out_y       <= '0;
      r_theta       <= '0;
      r_theta_valid <= 1'b0;
    end else begin
      r_theta_valid <= w_done && w_col0;
      if (w_done) begin
        r_out_x <= cor_x_out;
        if (w_col0) begin
          r_theta <= cor_z_out;
          r_out_y <= '0;
        end else begin
          r_out_y <= cor_y_out;
        end
      end
    end
  end

  assign in_ready    = (r_state == S_ACCEPT);
  assign out_valid   = (r_state == S_OUT);
  assign cor_enable  = (r_state == S_RUN);
  assign busy        = (r_state != S_ACCEPT) || !w_col0;
  assign out_x       = r_out_x;
  assign out_y       = r_out_y;
  assign out_col     = r_col;
  assign out_last    = (r_col == LAST_COL);
  assign theta       = r_theta;
  assign theta_valid = r_theta_valid;
  assign cor_select  = r_cor_select;
  assign cor_x_in    = r_cor_x_in;
  assign cor_y_in    = r_cor_y_in;
  assign cor_z_in    = r_cor_z_in;

endmodule

// File: tb/tb_givens_row_sequencer.sv
// Table-driven bench for givens_row_sequencer with a real-arithmetic cordic stub.
// Define GIVENS_TIMEOUT_EN to also exercise the watchdog.
module tb_givens_row_sequencer;

  localparam int TB_DW  = 32;
  localparam int TB_NC  = 4;
  localparam int TB_TMO = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [TB_DW-1:0]  in_x, in_y;
  logic              out_valid;
  logic              out_ready;
  logic [TB_DW-1:0]  out_x, out_y;
  logic [3:0]        out_col;
  logic              out_last;
  logic [TB_DW-1:0]  theta;
  logic              theta_valid;
  logic              busy;
  logic              cor_select, cor_enable;
  logic [TB_DW-1:0]  cor_x_in, cor_y_in, cor_z_in;
  logic [TB_DW-1:0]  cor_x_out, cor_y_out, cor_z_out;
  logic              cor_done;
`ifdef GIVENS_TIMEOUT_EN
  logic              err;
`endif

  givens_row_sequencer #(
    .DATA_W(TB_DW), .N_COLS(TB_NC), .TIMEOUT_CYC(TB_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_col(out_col), .out_last(out_last),
    .theta(theta), .theta_valid(theta_valid), .busy(busy),
    .cor_select(cor_select), .cor_enable(cor_enable),
    .cor_x_in(cor_x_in), .cor_y_in(cor_y_in), .cor_z_in(cor_z_in),
    .cor_x_out(cor_x_out), .cor_y_out(cor_y_out), .cor_z_out(cor_z_out),
    .cor_done(cor_done)
`ifdef GIVENS_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        sel;
    logic [31:0] z;
    logic        chk;
    logic [31:0] ex;
    logic [31:0] ey;
    logic [3:0]  col;
    logic        last;
    logic        tv;
    logic [31:0] th;
    int          lat;
    int          hold;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic        force_z_en = 1'b0;
  logic [31:0] force_z_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp);
    longint d;
    n_cmp++;
    d = longint'($signed(act)) - longint'($signed(exp));
    if (d < 0) d = -d;
    if (d > 64'sh0000FFFF) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h +/-0xFFFF", name, act, exp);
    end
  endtask

  function automatic logic [31:0] to_q(input real r);
    longint l;
    l = longint'(r * 16777216.0);
    return l[31:0];
  endfunction

  // Ideal gain-compensated cordic; vectoring leaves a small residual in y.
  task automatic cordic_model(input logic sel, input logic [31:0] x, y, z,
                              output logic [31:0] ox, oy, oz);
    real rx, ry, rz;
    rx = real'($signed(x)) / 16777216.0;
    ry = real'($signed(y)) / 16777216.0;
    rz = real'($signed(z)) / 16777216.0;
    if (sel) begin
      ox = to_q($sqrt(rx * rx + ry * ry));
      oy = 32'h0000_0005;
      oz = to_q($atan2(ry, rx));
    end else begin
      ox = to_q(rx * $cos(rz) - ry * $sin(rz));
      oy = to_q(rx * $sin(rz) + ry * $cos(rz));
      oz = '0;
    end
  endtask

  task automatic run_pair(input vec_t v);
    logic [31:0] mx, my, mz, sx, sy;
    @(negedge clk);
    check("accept_in_ready", {31'd0, in_ready}, 32'd1);
    in_x = v.in_x; in_y = v.in_y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("run_cor_enable", {31'd0, cor_enable}, 32'd1);
    check("run_in_ready", {31'd0, in_ready}, 32'd0);
    check("run_cor_select", {31'd0, cor_select}, {31'd0, v.sel});
    check("run_cor_x_in", cor_x_in, v.in_x);
    check("run_cor_y_in", cor_y_in, v.in_y);
    check_tol("run_cor_z_in", cor_z_in, v.z);
    repeat (v.lat) @(negedge clk);
    check("run_held_enable", {31'd0, cor_enable}, 32'd1);
    check("run_held_out_valid", {31'd0, out_valid}, 32'd0);
    cordic_model(cor_select, cor_x_in, cor_y_in, cor_z_in, mx, my, mz);
    cor_x_out = mx; cor_y_out = my;
    cor_z_out = force_z_en ? force_z_val : mz;
    cor_done = 1'b1;
    @(negedge clk);
    cor_done = 1'b0;
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_cor_enable", {31'd0, cor_enable}, 32'd0);
    check("out_col", {28'd0, out_col}, {28'd0, v.col});
    check("out_last", {31'd0, out_last}, {31'd0, v.last});
    check("theta_valid", {31'd0, theta_valid}, {31'd0, v.tv});
    if (v.chk) begin
      check_tol("out_x", out_x, v.ex);
      if (v.sel) begin
        check("out_y_forced0", out_y, v.ey);
        check_tol("theta", theta, v.th);
      end else begin
        check_tol("out_y", out_y, v.ey);
      end
    end
    sx = out_x; sy = out_y;
    for (int k = 0; k < v.hold; k++) begin
      if (k == 0) begin
        cor_done = 1'b1; cor_x_out = 32'h1234_5678; cor_y_out = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      cor_done = 1'b0;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_x", out_x, sx);
      check("bp_out_y", out_y, sy);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_cor_enable", {31'd0, cor_enable}, 32'd0);
      check("bp_theta_valid", {31'd0, theta_valid}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_theta_valid", {31'd0, theta_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, {31'd0, (v.col != 4'(TB_NC - 1))});
  endtask

  vec_t vec [6];
  vec_t sv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    cor_x_out = '0; cor_y_out = '0; cor_z_out = '0; cor_done = 1'b0;

    //        in_x          in_y          sel z             chk ex            ey            col   last tv th            lat hold
    vec[0] = '{32'h01000000, 32'h00800000, 1'b1, 32'h00000000, 1'b1, 32'h011E3779, 32'h00000000, 4'd0, 1'b0, 1'b1, 32'h0076B19C, 1, 10};
    vec[1] = '{32'h01000000, 32'h00000000, 1'b0, 32'hFF894E64, 1'b1, 32'h00E4F92E, 32'hFF8D8369, 4'd1, 1'b0, 1'b0, 32'h0, 2, 0};
    vec[2] = '{32'h00000000, 32'h01000000, 1'b0, 32'hFF894E64, 1'b1, 32'h00727C97, 32'h00E4F92E, 4'd2, 1'b0, 1'b0, 32'h0, 0, 2};
    vec[3] = '{32'h00800000, 32'h00800000, 1'b0, 32'hFF894E64, 1'b1, 32'h00ABBAE2, 32'h00393E4B, 4'd3, 1'b1, 1'b0, 32'h0, 3, 0};
    vec[4] = '{32'h02000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'h02000000, 32'h00000000, 4'd0, 1'b0, 1'b1, 32'h00000000, 1, 0};
    vec[5] = '{32'h01000000, 32'h01000000, 1'b0, 32'h00000000, 1'b1, 32'h01000000, 32'h01000000, 4'd1, 1'b0, 1'b0, 32'h0, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cor_enable", {31'd0, cor_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_theta", theta, 32'd0);
    check("rst_out_col", {28'd0, out_col}, 32'd0);
    check("rst_cor_select", {31'd0, cor_select}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_pair(vec[i]);
    check("theta_after_row2", theta, 32'd0);

    // Reset asserted mid-RUN on column 2 takes effect without a clock edge.
    @(negedge clk);
    in_x = 32'h01000000; in_y = 32'h00400000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_run_col", {28'd0, out_col}, 32'd2);
    check("mid_run_enable", {31'd0, cor_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cor_enable", {31'd0, cor_enable}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_theta", theta, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_col", {28'd0, out_col}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // Captured theta of the most negative code must negate to the most positive.
    force_z_en = 1'b1; force_z_val = 32'h80000000;
    sv = '{32'h01000000, 32'h00000000, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 32'h0, 1, 0};
    run_pair(sv);
    force_z_en = 1'b0;
    check("sat_theta", theta, 32'h80000000);
    sv = '{32'h01000000, 32'h00000000, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 32'h0, 0, 0};
    run_pair(sv);
    check("sat_cor_z_in", cor_z_in, 32'h7FFFFFFF);

`ifdef GIVENS_TIMEOUT_EN
    @(negedge clk);
    check("tmo_err_clear", {31'd0, err}, 32'd0);
    in_x = 32'h01000000; in_y = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < TB_TMO; k++) begin
      @(negedge clk);
      check("tmo_wait_enable", {31'd0, cor_enable & ~err}, 32'd1);
    end
    @(negedge clk);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_cor_enable", {31'd0, cor_enable}, 32'd0);
    check("tmo_out_valid", {31'd0, out_valid}, 32'd0);
    check("tmo_in_ready", {31'd0, in_ready}, 32'd1);
    check("tmo_col", {28'd0, out_col}, 32'd0);
    sv = '{32'h01000000, 32'h00800000, 1'b1, 32'h0, 1'b1, 32'h011E3779, 32'h0, 4'd0, 1'b0, 1'b1, 32'h0076B19C, 1, 0};
    run_pair(sv);
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
